// File: rtl/lui_addi_fuse_ctrl_pkg.sv
// Shared definitions for the LUI+ADDI fusion controller.
//   - RISC-V major opcodes used by the decode and fusion logic
//   - ImmSrc encodings (immediate class driven onto ImmSrcD)
//   - fusion FSM state type
//   - extend_imm32: the core's extend unit, producing the 32-bit
//     sign-correct immediate for a given class (callers sign-extend to XLEN)
package lui_addi_fuse_ctrl_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_AMO    = 7'b0101111;

  localparam logic [2:0] IMM_I     = 3'b000;
  localparam logic [2:0] IMM_S     = 3'b001;
  localparam logic [2:0] IMM_B     = 3'b010;
  localparam logic [2:0] IMM_J     = 3'b011;
  localparam logic [2:0] IMM_U     = 3'b100;
  localparam logic [2:0] IMM_ZERO  = 3'b101;
  localparam logic [2:0] IMM_FUSED = 3'b110;
  localparam logic [2:0] IMM_NONE  = 3'b111;

  typedef enum logic {
    FUSE_IDLE = 1'b0,
    FUSE_HOLD = 1'b1
  } fuse_state_e;

  // Every RV immediate fits in 32 bits when sign-extended, so the extend
  // unit works at 32 bits and the caller widens with a signed cast.
  function automatic logic [31:0] extend_imm32(input logic [31:0] instr,
                                               input logic [2:0]  immsrc);
    logic [31:0] imm;
    case (immsrc)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      default: imm = 32'b0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/lui_addi_fuse_ctrl_imm_class_decode.sv
// imm_class_decode: maps a major opcode to its immediate class.
// Purely combinational.
//   op     in  7  instruction opcode field [6:0]
//   immsrc out 3  immediate class (IMM_* encodings)
module imm_class_decode
  import lui_addi_fuse_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [2:0] immsrc
);

  always_comb begin
    immsrc = IMM_NONE;
    case (op)
      OP_IMM, OP_LOAD, OP_JALR, OP_IMM32: immsrc = IMM_I;
      OP_STORE:                           immsrc = IMM_S;
      OP_BRANCH:                          immsrc = IMM_B;
      OP_JAL:                             immsrc = IMM_J;
      OP_LUI, OP_AUIPC:                   immsrc = IMM_U;
      OP_AMO:                             immsrc = IMM_ZERO;
      default:                            immsrc = IMM_NONE;
    endcase
  end

endmodule

// File: rtl/lui_addi_fuse_ctrl.sv
// lui_addi_fuse_ctrl: decode-stage LUI+ADDI macro-op fusion.
// A LUI (rd != 0) is held for up to HOLD_TIMEOUT idle cycles; if the next
// instruction is ADDI rd,rd,imm on the same rd, a single fused slot with the
// full XLEN constant is issued. Otherwise instructions issue unfused.
//   clk          in   1     clock
//   reset_n      in   1     asynchronous active-low reset
//   FlushD       in   1     flush held LUI and output slot (beats stall)
//   StallD       in   1     freeze all state and output registers
//   InstrValidF  in   1     fetch instruction valid
//   InstrF       in   32    fetch instruction
//   InstrReadyF  out  1     instruction consumed when valid & ready
//   InstrValidD  out  1     decode slot valid
//   InstrD       out  32    issued instruction (ADDI word when fused)
//   ImmSrcD      out  3     immediate class, 3'b110 = fused
//   ImmExtD      out  XLEN  extended immediate
//   FusedD       out  1     slot carries a fused op
module lui_addi_fuse_ctrl
  import lui_addi_fuse_ctrl_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int HOLD_TIMEOUT = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            FlushD,
  input  logic            StallD,
  input  logic            InstrValidF,
  input  logic [31:0]     InstrF,
  output logic            InstrReadyF,
  output logic            InstrValidD,
  output logic [31:0]     InstrD,
  output logic [2:0]      ImmSrcD,
  output logic [XLEN-1:0] ImmExtD,
  output logic            FusedD
);

  localparam int CNT_W = $clog2(HOLD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_TIMEOUT - 1);

  fuse_state_e      state_reg, state_next;
  logic [31:0]      hold_instr_reg, hold_instr_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic             valid_reg, valid_next;
  logic [31:0]      instr_reg, instr_next;
  logic [2:0]       immsrc_reg, immsrc_next;
  logic [XLEN-1:0]  immext_reg, immext_next;
  logic             fused_reg, fused_next;

  logic             is_hold;
  logic             match;
  logic             lui_capture;
  logic [31:0]      issue_instr;
  logic [2:0]       issue_immsrc;
  logic signed [31:0] issue_imm32;
  logic signed [31:0] lui_imm32;
  logic signed [31:0] addi_imm32;
  logic [XLEN-1:0]  issue_immext;
  logic [XLEN-1:0]  fused_immext;

  assign is_hold = (state_reg == FUSE_HOLD);

  assign match = (InstrF[6:0] == OP_IMM) && (InstrF[14:12] == 3'b000) &&
                 (InstrF[11:7] == hold_instr_reg[11:7]) &&
                 (InstrF[19:15] == hold_instr_reg[11:7]) &&
                 (hold_instr_reg[11:7] != 5'd0);

  // A non-matching instruction in HOLD is refused so the held LUI can be
  // issued first; the fetch side re-presents it next cycle. During a flush
  // the presented instruction is consumed and dropped.
  assign InstrReadyF = FlushD | (~StallD & ~(is_hold & InstrValidF & ~match));

  assign lui_capture = (InstrF[6:0] == OP_LUI) && (InstrF[11:7] != 5'd0);

  // Unfused issue always comes from the held LUI when in HOLD, else from fetch,
  // so a single decoder/extend path serves both.
  assign issue_instr = is_hold ? hold_instr_reg : InstrF;

  imm_class_decode u_imm_class_decode (
    .op     (issue_instr[6:0]),
    .immsrc (issue_immsrc)
  );

  assign issue_imm32  = extend_imm32(issue_instr, issue_immsrc);
  assign issue_immext = XLEN'(issue_imm32);

  // Both halves are sign-extended to XLEN before the add so RV64 keeps the
  // upper bits of the constant instead of wrapping at 32 bits.
  assign lui_imm32    = {hold_instr_reg[31:12], 12'b0};
  assign addi_imm32   = {{20{InstrF[31]}}, InstrF[31:20]};
  assign fused_immext = XLEN'(lui_imm32) + XLEN'(addi_imm32);

  always_comb begin
    state_next      = state_reg;
    hold_instr_next = hold_instr_reg;
    cnt_next        = cnt_reg;
    valid_next      = valid_reg;
    instr_next      = instr_reg;
    immsrc_next     = immsrc_reg;
    immext_next     = immext_reg;
    fused_next      = fused_reg;

    if (FlushD) begin
      state_next = FUSE_IDLE;
      cnt_next   = '0;
      valid_next = 1'b0;
      fused_next = 1'b0;
    end else if (!StallD) begin
      valid_next = 1'b0;
      case (state_reg)
        FUSE_IDLE: begin
          if (InstrValidF) begin
            if (lui_capture) begin
              hold_instr_next = InstrF;
              cnt_next        = '0;
              state_next      = FUSE_HOLD;
            end else begin
              valid_next  = 1'b1;
              instr_next  = issue_instr;
              immsrc_next = issue_immsrc;
              immext_next = issue_immext;
              fused_next  = 1'b0;
            end
          end
        end
        FUSE_HOLD: begin
          if (InstrValidF && match) begin
            valid_next  = 1'b1;
            instr_next  = InstrF;
            immsrc_next = IMM_FUSED;
            immext_next = fused_immext;
            fused_next  = 1'b1;
            cnt_next    = '0;
            state_next  = FUSE_IDLE;
          end else if (InstrValidF || (cnt_reg == CNT_LAST)) begin
            valid_next  = 1'b1;
            instr_next  = issue_instr;
            immsrc_next = issue_immsrc;
            immext_next = issue_immext;
            fused_next  = 1'b0;
            cnt_next    = '0;
            state_next  = FUSE_IDLE;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        default: state_next = FUSE_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= FUSE_IDLE;
      hold_instr_reg <= '0;
      cnt_reg        <= '0;
      valid_reg      <= 1'b0;
      instr_reg      <= '0;
      immsrc_reg     <= IMM_NONE;
      immext_reg     <= '0;
      fused_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      hold_instr_reg <= hold_instr_next;
      cnt_reg        <= cnt_next;
      valid_reg      <= valid_next;
      instr_reg      <= instr_next;
      immsrc_reg     <= immsrc_next;
      immext_reg     <= immext_next;
      fused_reg      <= fused_next;
    end
  end

  assign InstrValidD = valid_reg;
  assign InstrD      = instr_reg;
  assign ImmSrcD     = immsrc_reg;
  assign ImmExtD     = immext_reg;
  assign FusedD      = fused_reg;

endmodule

// File: tb/tb_lui_addi_fuse_ctrl.sv
// Directed self-checking bench for lui_addi_fuse_ctrl (XLEN=64, HOLD_TIMEOUT=4).
module tb_lui_addi_fuse_ctrl;

  localparam int XLEN = 64;

  localparam logic [31:0] LUI5      = 32'h123452B7; // lui  x5,0x12345
  localparam logic [31:0] LUI5_HI   = 32'h800002B7; // lui  x5,0x80000
  localparam logic [31:0] LUI0      = 32'h12345037; // lui  x0,0x12345
  localparam logic [31:0] ADDI_678  = 32'h67828293; // addi x5,x5,0x678
  localparam logic [31:0] ADDI_M1   = 32'hFFF28293; // addi x5,x5,-1
  localparam logic [31:0] ADDI_X6   = 32'h00128313; // addi x6,x5,1

  logic            clk;
  logic            reset_n;
  logic            FlushD;
  logic            StallD;
  logic            InstrValidF;
  logic [31:0]     InstrF;
  logic            InstrReadyF;
  logic            InstrValidD;
  logic [31:0]     InstrD;
  logic [2:0]      ImmSrcD;
  logic [XLEN-1:0] ImmExtD;
  logic            FusedD;

  int n_checks = 0;
  int n_fail   = 0;

  lui_addi_fuse_ctrl #(.XLEN(XLEN), .HOLD_TIMEOUT(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .FlushD      (FlushD),
    .StallD      (StallD),
    .InstrValidF (InstrValidF),
    .InstrF      (InstrF),
    .InstrReadyF (InstrReadyF),
    .InstrValidD (InstrValidD),
    .InstrD      (InstrD),
    .ImmSrcD     (ImmSrcD),
    .ImmExtD     (ImmExtD),
    .FusedD      (FusedD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins);
    InstrValidF = v;
    InstrF      = ins;
  endtask

  task automatic check_slot(input string tag, input logic [31:0] ins, input logic [2:0] src,
                            input logic [63:0] imm, input logic f);
    $display("slot %s: valid=%0b instr=%08h immsrc=%03b immext=%016h fused=%0b",
             tag, InstrValidD, InstrD, ImmSrcD, ImmExtD, FusedD);
    check({tag, ".valid"},  64'(InstrValidD), 64'(1'b1));
    check({tag, ".instr"},  64'(InstrD), 64'(ins));
    check({tag, ".immsrc"}, 64'(ImmSrcD), 64'(src));
    check({tag, ".immext"}, ImmExtD, imm);
    check({tag, ".fused"},  64'(FusedD), 64'(f));
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [2:0]  src;
    logic [63:0] imm;
  } vec_t;

  vec_t unfused_tbl[8];

  initial begin
    unfused_tbl[0] = '{32'h00512423, 3'b001, 64'h8};                  // sw   x5,8(x2)
    unfused_tbl[1] = '{32'hFE000EE3, 3'b010, 64'hFFFFFFFFFFFFFFFC};   // beq  x0,x0,-4
    unfused_tbl[2] = '{32'h0080006F, 3'b011, 64'h8};                  // jal  x0,8
    unfused_tbl[3] = '{32'h00001097, 3'b100, 64'h1000};               // auipc x1,1
    unfused_tbl[4] = '{32'hFFC12083, 3'b000, 64'hFFFFFFFFFFFFFFFC};   // lw   x1,-4(x2)
    unfused_tbl[5] = '{32'h0000202F, 3'b101, 64'h0};                  // amo
    unfused_tbl[6] = '{32'h0000000B, 3'b111, 64'h0};                  // custom-0
    unfused_tbl[7] = '{LUI0,         3'b100, 64'h12345000};           // lui x0 never held

    reset_n = 1'b0; FlushD = 1'b0; StallD = 1'b0; InstrValidF = 1'b0; InstrF = '0;
    #12;
    $display("reset: valid=%0b immsrc=%03b immext=%0h", InstrValidD, ImmSrcD, ImmExtD);
    check("rst.valid",  64'(InstrValidD), 64'(1'b0));
    check("rst.instr",  64'(InstrD), 64'h0);
    check("rst.immsrc", 64'(ImmSrcD), 64'(3'b111));
    check("rst.immext", ImmExtD, 64'h0);
    check("rst.fused",  64'(FusedD), 64'(1'b0));
    check("rst.ready",  64'(InstrReadyF), 64'(1'b1));
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Back-to-back fusion
    drive(1'b1, LUI5); #1;
    check("A.ready_lui", 64'(InstrReadyF), 64'(1'b1));
    tick();
    check("A.held_novalid", 64'(InstrValidD), 64'(1'b0));
    drive(1'b1, ADDI_678); #1;
    check("A.ready_addi", 64'(InstrReadyF), 64'(1'b1));
    tick();
    check_slot("A.fused", ADDI_678, 3'b110, 64'h12345678, 1'b1);
    drive(1'b0, 32'h0);
    tick();
    check("A.after.valid", 64'(InstrValidD), 64'(1'b0));
    check("A.after.hold", ImmExtD, 64'h12345678);

    // Negative ADDI immediate, and RV64 upper-bit carry
    drive(1'b1, LUI5); tick();
    drive(1'b1, ADDI_M1); tick();
    check_slot("B.neg", ADDI_M1, 3'b110, 64'h12344FFF, 1'b1);
    drive(1'b1, LUI5_HI); tick();
    drive(1'b1, ADDI_M1); tick();
    check_slot("B.rv64", ADDI_M1, 3'b110, 64'hFFFFFFFF7FFFFFFF, 1'b1);
    drive(1'b0, 32'h0); tick();

    // Non-matching ADDI releases the LUI first
    drive(1'b1, LUI5); tick();
    drive(1'b1, ADDI_X6); #1;
    check("C.ready_refuse", 64'(InstrReadyF), 64'(1'b0));
    tick();
    check_slot("C.lui", LUI5, 3'b100, 64'h12345000, 1'b0);
    check("C.ready_again", 64'(InstrReadyF), 64'(1'b1));
    tick();
    check_slot("C.addi", ADDI_X6, 3'b000, 64'h1, 1'b0);
    drive(1'b0, 32'h0); tick();

    // Timeout: LUI released exactly 4 cycles after entering HOLD
    drive(1'b1, LUI5); tick();
    drive(1'b0, 32'h0);
    for (int i = 1; i < 4; i++) begin
      tick();
      check($sformatf("D.wait%0d", i), 64'(InstrValidD), 64'(1'b0));
    end
    tick();
    check_slot("D.timeout", LUI5, 3'b100, 64'h12345000, 1'b0);
    tick();

    // Unfused immediate classes, back-to-back in IDLE
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, unfused_tbl[i].ins);
      tick();
      check_slot($sformatf("E.cls%0d", i), unfused_tbl[i].ins, unfused_tbl[i].src,
                 unfused_tbl[i].imm, 1'b0);
    end
    drive(1'b0, 32'h0); tick();

    // Stall with ADDI presented: nothing consumed, then fuses
    drive(1'b1, LUI5); tick();
    drive(1'b1, ADDI_678); StallD = 1'b1; #1;
    check("F.ready_stall", 64'(InstrReadyF), 64'(1'b0));
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("F.stall%0d", i), 64'(InstrValidD), 64'(1'b0));
    end
    StallD = 1'b0;
    tick();
    check_slot("F.fused", ADDI_678, 3'b110, 64'h12345678, 1'b1);
    drive(1'b0, 32'h0); tick();

    // Stall freezes the hold counter
    drive(1'b1, LUI5); tick();
    drive(1'b0, 32'h0);
    tick(); tick();
    StallD = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    StallD = 1'b0;
    tick();
    check("G.cnt3_novalid", 64'(InstrValidD), 64'(1'b0));
    tick();
    check_slot("G.timeout", LUI5, 3'b100, 64'h12345000, 1'b0);
    tick();

    // Flush coincident with matching ADDI
    drive(1'b1, LUI5); tick();
    drive(1'b1, ADDI_678); FlushD = 1'b1; #1;
    check("H.ready_flush", 64'(InstrReadyF), 64'(1'b1));
    tick();
    check("H.flush.valid", 64'(InstrValidD), 64'(1'b0));
    check("H.flush.fused", 64'(FusedD), 64'(1'b0));
    FlushD = 1'b0; drive(1'b0, 32'h0);
    tick();
    check("H.idle.valid", 64'(InstrValidD), 64'(1'b0));
    drive(1'b1, ADDI_678); tick();
    check_slot("H.addi_alone", ADDI_678, 3'b000, 64'h678, 1'b0);

    // Asynchronous reset mid-HOLD
    drive(1'b1, LUI0); tick();
    drive(1'b1, LUI5); tick();
    check("I.hold.immext", ImmExtD, 64'h12345000);
    drive(1'b0, 32'h0);
    #1 reset_n = 1'b0;
    #1;
    $display("async reset: valid=%0b immsrc=%03b immext=%0h", InstrValidD, ImmSrcD, ImmExtD);
    check("I.rst.valid",  64'(InstrValidD), 64'(1'b0));
    check("I.rst.immext", ImmExtD, 64'h0);
    check("I.rst.immsrc", 64'(ImmSrcD), 64'(3'b111));
    #2 reset_n = 1'b1;
    drive(1'b1, ADDI_678); tick();
    check_slot("I.addi_after_rst", ADDI_678, 3'b000, 64'h678, 1'b0);
    drive(1'b0, 32'h0); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
